// File: rtl/chan_event_counter_4_pkg.sv
// Shared constants and types for the per-channel event counter.
// Imported by the interface, the counter cell and the top.
package chan_event_counter_4_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_t;

endpackage

// File: rtl/chan_event_counter_4_if.sv
// Read-back handshake bundle: request/select/clear in, held data out.
// The consumer drives the master side, the counter block is the slave.
interface chan_event_counter_4_if
    import chan_event_counter_4_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             i_rd_req;
    logic [SEL_W-1:0] i_rd_sel;
    logic             i_clr_on_rd;
    logic             i_rd_ack;
    logic             o_rd_valid;
    logic [CNT_W-1:0] o_rd_data;
    logic [SEL_W-1:0] o_rd_sel;

    modport master (
        output i_rd_req,
        output i_rd_sel,
        output i_clr_on_rd,
        output i_rd_ack,
        input  o_rd_valid,
        input  o_rd_data,
        input  o_rd_sel
    );

    modport slave (
        input  i_rd_req,
        input  i_rd_sel,
        input  i_clr_on_rd,
        input  i_rd_ack,
        output o_rd_valid,
        output o_rd_data,
        output o_rd_sel
    );

endinterface

// File: rtl/chan_event_counter_4_sat_cnt.sv
// Saturating event counter; a clear with a coincident event leaves 1.
// at_max flags the all-ones value so the parent can raise saturation.
module chan_event_counter_4_sat_cnt
    import chan_event_counter_4_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = &cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/chan_event_counter_4.sv
// Counts rising edges on each line of a one-hot code bus and
// returns one channel's count at a time over a valid/ack handshake.
module chan_event_counter_4
    import chan_event_counter_4_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_code,
    chan_event_counter_4_if.slave rd,
    output logic [NUM_CH-1:0] o_sat,
    output logic              o_err
);

    logic [NUM_CH-1:0] code_q;
    logic [NUM_CH-1:0] code_prev;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] at_max;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic              multi;
    logic              cap;
    rd_state_t         state_q;
    rd_state_t         state_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            code_q    <= '0;
            code_prev <= '0;
        end else begin
            code_q    <= i_code;
            code_prev <= code_q;
        end
    end

    // Clearing the lowest set bit leaves a residue only when multi-hot.
    assign multi = |(code_q & (code_q - NUM_CH'(1)));
    assign rise  = code_q & ~code_prev;
    assign inc   = multi ? '0 : rise;

    always_comb begin
        clr = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            clr[k] = cap && rd.i_clr_on_rd &&
                     (rd.i_rd_sel == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        chan_event_counter_4_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .inc    (inc[k]),
            .clr    (clr[k]),
            .cnt    (cnt[k]),
            .at_max (at_max[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sat <= '0;
            o_err <= 1'b0;
        end else begin
            o_sat <= (o_sat | (inc & at_max)) & ~clr;
            o_err <= o_err | multi;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (rd.i_rd_req) begin
                    cap     = 1'b1;
                    state_d = HOLD;
                end
            end
            (state_q == HOLD): begin
                if (rd.i_rd_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd.o_rd_valid = (state_q == HOLD);

    // Capture sees the counter before this edge's clear/increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd.o_rd_data <= '0;
            rd.o_rd_sel  <= '0;
        end else if (cap) begin
            rd.o_rd_data <= cnt[rd.i_rd_sel];
            rd.o_rd_sel  <= rd.i_rd_sel;
        end
    end

endmodule

// File: tb/tb_chan_event_counter_4.sv
// Directed bench for chan_event_counter_4 with a read-result queue
// filled at request time and drained when read data is presented.
module tb_chan_event_counter_4;
    import chan_event_counter_4_pkg::*;

    localparam int CNT_W = 8;
    localparam int MAXV  = (1 << CNT_W) - 1;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [CNT_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] code;
    logic [NUM_CH-1:0] sat;
    logic              err;

    chan_event_counter_4_if #(.CNT_W(CNT_W)) rd_if ();

    chan_event_counter_4 #(
        .CNT_W (CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_code  (code),
        .rd      (rd_if),
        .o_sat   (sat),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    int          mcnt[NUM_CH];
    logic [3:0]  msat;
    logic        merr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) mcnt[k] = 0;
        msat = '0;
        merr = 1'b0;
    endtask

    // One high sample then one low sample; counter settles by return.
    task automatic pulse(input logic [3:0] v);
        code = v;
        tick();
        code = '0;
        tick();
        if ($countones(v) > 1) begin
            merr = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (v[k]) begin
                    if (mcnt[k] == MAXV) msat[k] = 1'b1;
                    else mcnt[k]++;
                end
            end
        end
    endtask

    task automatic rd_issue(input int sel, input bit clr);
        exp_t e;
        e.sel  = SEL_W'(sel);
        e.data = CNT_W'(mcnt[sel]);
        sb.push_back(e);
        if (clr) begin
            mcnt[sel] = 0;
            msat[sel] = 1'b0;
        end
        rd_if.i_rd_req    = 1'b1;
        rd_if.i_rd_sel    = SEL_W'(sel);
        rd_if.i_clr_on_rd = clr;
        tick();
        rd_if.i_rd_req    = 1'b0;
        rd_if.i_clr_on_rd = 1'b0;
    endtask

    task automatic rd_finish(input int hold);
        exp_t e;
        int   n = 0;
        while (!rd_if.o_rd_valid && n < 8) begin
            tick();
            n++;
        end
        chk("rd_valid", 32'(rd_if.o_rd_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("rd_data", 32'(rd_if.o_rd_data), 32'(e.data));
        chk("rd_sel", 32'(rd_if.o_rd_sel), 32'(e.sel));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(rd_if.o_rd_valid), 32'd1);
            chk("hold_data", 32'(rd_if.o_rd_data), 32'(e.data));
        end
        rd_if.i_rd_ack = 1'b1;
        tick();
        rd_if.i_rd_ack = 1'b0;
        chk("ack_drop", 32'(rd_if.o_rd_valid), 32'd0);
    endtask

    task automatic rd(input int sel, input bit clr, input int hold);
        rd_issue(sel, clr);
        rd_finish(hold);
    endtask

    initial begin
        model_reset();
        rst_n             = 1'b0;
        code              = 4'b1111;
        rd_if.i_rd_req    = 1'b1;
        rd_if.i_rd_sel    = '0;
        rd_if.i_clr_on_rd = 1'b0;
        rd_if.i_rd_ack    = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(rd_if.o_rd_valid), 32'd0);
        chk("rst_data", 32'(rd_if.o_rd_data), 32'd0);
        chk("rst_sel", 32'(rd_if.o_rd_sel), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        code           = '0;
        rd_if.i_rd_req = 1'b0;
        rst_n          = 1'b1;
        repeat (2) tick();
        chk("post_rst_valid", 32'(rd_if.o_rd_valid), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        rd(3, 1'b0, 0);

        // Line held high counts once.
        code = 4'b0100;
        repeat (5) tick();
        code = '0;
        tick();
        mcnt[2] = 1;
        rd(2, 1'b0, 2);

        for (int i = 0; i < 10; i++) pulse(4'b0001);
        rd(0, 1'b1, 4);
        rd(0, 1'b0, 0);

        for (int i = 0; i < 260; i++) pulse(4'b1000);
        chk("sat_set", 32'(sat), 32'(msat));
        rd(3, 1'b1, 0);
        chk("sat_clr", 32'(sat), 32'(msat));
        rd(3, 1'b0, 0);

        pulse(4'b0011);
        tick();
        chk("err_set", 32'(err), 32'(merr));
        pulse(4'b0001);
        rd(0, 1'b0, 0);
        rd(1, 1'b0, 0);
        chk("err_sticky", 32'(err), 32'd1);

        // Clear-on-read racing a rise on the same channel.
        for (int i = 0; i < 7; i++) pulse(4'b0010);
        code = 4'b0010;
        tick();
        rd_issue(1, 1'b1);
        code    = '0;
        mcnt[1] = 1;
        rd_finish(0);
        rd(1, 1'b0, 0);

        rd_issue(2, 1'b0);
        chk("pre_rst_valid", 32'(rd_if.o_rd_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("hold_rst_valid", 32'(rd_if.o_rd_valid), 32'd0);
        chk("hold_rst_data", 32'(rd_if.o_rd_data), 32'd0);
        chk("hold_rst_err", 32'(err), 32'd0);
        void'(sb.pop_front());
        model_reset();
        rst_n = 1'b1;
        tick();
        rd(2, 1'b0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
